// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared definitions for the GPIO interrupt port: the register address map
// as plain integer constants and as an enum used by the top-level decoder.
package gpio_pkg;

  localparam int GPIO_DATA       = 0;
  localparam int GPIO_DIR        = 1;
  localparam int GPIO_OUT_SET    = 2;
  localparam int GPIO_OUT_CLR    = 3;
  localparam int GPIO_IRQ_MASK   = 4;
  localparam int GPIO_RISE_EN    = 5;
  localparam int GPIO_FALL_EN    = 6;
  localparam int GPIO_IRQ_STATUS = 7;

  typedef enum logic [2:0] {
    ADDR_DATA       = 3'(GPIO_DATA),
    ADDR_DIR        = 3'(GPIO_DIR),
    ADDR_OUT_SET    = 3'(GPIO_OUT_SET),
    ADDR_OUT_CLR    = 3'(GPIO_OUT_CLR),
    ADDR_IRQ_MASK   = 3'(GPIO_IRQ_MASK),
    ADDR_RISE_EN    = 3'(GPIO_RISE_EN),
    ADDR_FALL_EN    = 3'(GPIO_FALL_EN),
    ADDR_IRQ_STATUS = 3'(GPIO_IRQ_STATUS)
  } gpio_addr_e;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge
// Input synchroniser and edge detector for the GPIO pins. Each pin passes
// through SYNC_STAGES flops; one further flop holds the previous synchronised
// value so that rising/falling edges can be detected per pin.
//
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   i_pins     in   raw pin values (PIN_W)
//   i_rise_en  in   per-pin rising-edge enable
//   i_fall_en  in   per-pin falling-edge enable
//   o_sync     out  synchronised pin values
//   o_rise     out  enabled rising edges this cycle
//   o_fall     out  enabled falling edges this cycle
module gpio_sync_edge #(
  parameter int PIN_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [PIN_W-1:0] i_pins,
  input  logic [PIN_W-1:0] i_rise_en,
  input  logic [PIN_W-1:0] i_fall_en,
  output logic [PIN_W-1:0] o_sync,
  output logic [PIN_W-1:0] o_rise,
  output logic [PIN_W-1:0] o_fall
);

  // r_stage[0] is the first (metastability-catching) flop.
  logic [SYNC_STAGES-1:0][PIN_W-1:0] r_stage;
  logic [PIN_W-1:0]                  r_prev;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
      r_prev  <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], i_pins};
      r_prev  <= r_stage[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev & i_rise_en;
  assign o_fall = ~o_sync & r_prev & i_fall_en;

endmodule

// File: rtl/gpio_irq_port.sv
// gpio_irq_port
// Peribus GPIO controller: per-pin direction, atomic set/clear of output
// bits, synchronised pin readback and per-pin edge interrupts with mask and
// write-1-to-clear status.
//
// Ports:
//   clock       in     system clock
//   reset_n     in     asynchronous active-low reset
//   chipselect  in     qualifies read_en / write_en
//   addr        in     register select (ADDR_W)
//   write_data  in     write data (DATA_W)
//   write_en    in     write strobe
//   read_en     in     read strobe
//   read_data   out    registered read data, valid the cycle after the read
//   irq         out    registered level interrupt, |(status & mask)
//   bidir_port  inout  pins, driven where DIR=1, high-Z otherwise
module gpio_irq_port
  import gpio_pkg::*;
#(
  parameter int PIN_W       = 16,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_en,
  input  logic              read_en,
  output logic [DATA_W-1:0] read_data,
  output logic              irq,
  inout  wire  [PIN_W-1:0]  bidir_port
);

  logic [PIN_W-1:0]  r_out;
  logic [PIN_W-1:0]  r_dir;
  logic [PIN_W-1:0]  r_mask;
  logic [PIN_W-1:0]  r_rise_en;
  logic [PIN_W-1:0]  r_fall_en;
  logic [PIN_W-1:0]  r_status;
  logic [DATA_W-1:0] r_read_data;
  logic              r_irq;

  logic              w_wr;
  logic              w_rd;
  logic              w_in_map;
  gpio_addr_e        w_reg_sel;
  logic [PIN_W-1:0]  w_wd;
  logic [PIN_W-1:0]  w_sync;
  logic [PIN_W-1:0]  w_rise;
  logic [PIN_W-1:0]  w_fall;
  logic [PIN_W-1:0]  w_status_clr;
  logic [PIN_W-1:0]  w_rd_val;
  logic              w_unused_wd;

  assign w_wr      = chipselect & write_en;
  assign w_rd      = chipselect & read_en;
  // Address bits above the 8-entry map must be zero for a register hit.
  assign w_in_map  = ((addr >> 3) == '0);
  assign w_reg_sel = gpio_addr_e'(addr[2:0]);
  // Data bits at or above PIN_W are ignored on writes.
  assign w_wd        = write_data[PIN_W-1:0];
  assign w_unused_wd = ^write_data;

  gpio_sync_edge #(
    .PIN_W       (PIN_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock     (clock),
    .reset_n   (reset_n),
    .i_pins    (bidir_port),
    .i_rise_en (r_rise_en),
    .i_fall_en (r_fall_en),
    .o_sync    (w_sync),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  assign w_status_clr = (w_wr && w_in_map && w_reg_sel == ADDR_IRQ_STATUS) ? w_wd : '0;

  // Read mux works on current register values, so a read coinciding with a
  // write to the same address returns the pre-write contents.
  always_comb begin
    w_rd_val = '0;
    if (w_in_map) begin
      case (w_reg_sel)
        ADDR_DATA:       w_rd_val = w_sync;
        ADDR_DIR:        w_rd_val = r_dir;
        ADDR_IRQ_MASK:   w_rd_val = r_mask;
        ADDR_RISE_EN:    w_rd_val = r_rise_en;
        ADDR_FALL_EN:    w_rd_val = r_fall_en;
        ADDR_IRQ_STATUS: w_rd_val = r_status;
        default:         w_rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out       <= '0;
      r_dir       <= '0;
      r_mask      <= '0;
      r_rise_en   <= '0;
      r_fall_en   <= '0;
      r_status    <= '0;
      r_read_data <= '0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr && w_in_map) begin
        case (w_reg_sel)
          ADDR_DATA:     r_out     <= w_wd;
          ADDR_DIR:      r_dir     <= w_wd;
          ADDR_OUT_SET:  r_out     <= r_out | w_wd;
          ADDR_OUT_CLR:  r_out     <= r_out & ~w_wd;
          ADDR_IRQ_MASK: r_mask    <= w_wd;
          ADDR_RISE_EN:  r_rise_en <= w_wd;
          ADDR_FALL_EN:  r_fall_en <= w_wd;
          default:       ;
        endcase
      end
      // Clear applied first so a same-cycle edge on the bit keeps it set.
      r_status <= (r_status & ~w_status_clr) | w_rise | w_fall;
      r_irq    <= |(r_status & r_mask);
      if (w_rd) begin
        r_read_data <= DATA_W'(w_rd_val);
      end
    end
  end

  assign read_data = r_read_data;
  assign irq       = r_irq;

  for (genvar gi = 0; gi < PIN_W; gi++) begin : g_pin
    assign bidir_port[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_irq_port.sv
// Testbench for gpio_irq_port: a 16-pin instance and an 8-pin instance with a
// wider address bus, register table, hand-written interrupt timing
// sequences, and a randomized phase compared against a settled-state model.
module tb_gpio_irq_port;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  addr16;
  logic [3:0]  addr8;
  logic [15:0] wd;
  logic        we, re, cs16, cs8;
  logic [15:0] rd16, rd8;
  logic        irq16, irq8;
  wire  [15:0] pins16;
  wire  [7:0]  pins8;
  logic [15:0] ext16_val, ext16_en;
  logic [7:0]  ext8_val, ext8_en;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 16; gi++) begin : g_ext16
    assign pins16[gi] = ext16_en[gi] ? ext16_val[gi] : 1'bz;
  end
  for (genvar gi = 0; gi < 8; gi++) begin : g_ext8
    assign pins8[gi] = ext8_en[gi] ? ext8_val[gi] : 1'bz;
  end

  gpio_irq_port u_dut16 (
    .clock      (clock),
    .reset_n    (reset_n),
    .chipselect (cs16),
    .addr       (addr16),
    .write_data (wd),
    .write_en   (we),
    .read_en    (re),
    .read_data  (rd16),
    .irq        (irq16),
    .bidir_port (pins16)
  );

  gpio_irq_port #(.PIN_W(8), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2)) u_dut8 (
    .clock      (clock),
    .reset_n    (reset_n),
    .chipselect (cs8),
    .addr       (addr8),
    .write_data (wd),
    .write_en   (we),
    .read_en    (re),
    .read_data  (rd8),
    .irq        (irq8),
    .bidir_port (pins8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus_write(input bit sel8, input logic [3:0] a, input logic [15:0] d);
    @(negedge clock);
    cs16 = !sel8; cs8 = sel8; addr16 = a[2:0]; addr8 = a; wd = d; we = 1'b1;
    @(negedge clock);
    we = 1'b0; cs16 = 1'b0; cs8 = 1'b0;
  endtask

  task automatic bus_read(input bit sel8, input logic [3:0] a, output logic [15:0] d);
    @(negedge clock);
    cs16 = !sel8; cs8 = sel8; addr16 = a[2:0]; addr8 = a; re = 1'b1;
    @(negedge clock);
    re = 1'b0; cs16 = 1'b0; cs8 = 1'b0;
    d = sel8 ? rd8 : rd16;
  endtask

  typedef struct {
    bit          do_wr;
    logic [2:0]  wa;
    logic [15:0] wdat;
    logic [2:0]  ra;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[10];

  // Settled-state reference model for the randomized phase.
  logic [15:0] m_out, m_dir, m_mask, m_rise, m_fall, m_status, m_pins;

  function automatic logic [15:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return m_pins;
      3'd1: return m_dir;
      3'd4: return m_mask;
      3'd5: return m_rise;
      3'd6: return m_fall;
      3'd7: return m_status;
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic [15:0] newp;
    logic [2:0]  ra;

    reset_n = 1'b0; addr16 = '0; addr8 = '0; wd = '0; we = 0; re = 0; cs16 = 0; cs8 = 0;
    ext16_en = 16'hFFFF; ext16_val = 16'hA5A5;
    ext8_en = 8'hFF; ext8_val = 8'h3C;

    tbl[0] = '{1'b1, 3'd4, 16'hFFFF, 3'd4, 16'hFFFF};
    tbl[1] = '{1'b1, 3'd4, 16'h0000, 3'd4, 16'h0000};
    tbl[2] = '{1'b1, 3'd5, 16'hA5A5, 3'd5, 16'hA5A5};
    tbl[3] = '{1'b1, 3'd5, 16'h0000, 3'd5, 16'h0000};
    tbl[4] = '{1'b1, 3'd6, 16'h5A5A, 3'd6, 16'h5A5A};
    tbl[5] = '{1'b1, 3'd6, 16'h0000, 3'd6, 16'h0000};
    tbl[6] = '{1'b1, 3'd2, 16'hFFFF, 3'd2, 16'h0000};
    tbl[7] = '{1'b1, 3'd3, 16'hFFFF, 3'd3, 16'h0000};
    tbl[8] = '{1'b1, 3'd1, 16'h0000, 3'd1, 16'h0000};
    tbl[9] = '{1'b0, 3'd0, 16'h0000, 3'd7, 16'h0000};

    // Reset state
    repeat (3) @(negedge clock);
    check("reset_irq", {31'd0, irq16}, 32'd0);
    check("reset_rdata", {16'd0, rd16}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    bus_read(1'b0, 4'd0, r);
    check("reset_data_read", {16'd0, r}, {16'd0, 16'hA5A5});
    check("reset_irq_after", {31'd0, irq16}, 32'd0);

    // Register table
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].do_wr) bus_write(1'b0, {1'b0, tbl[i].wa}, tbl[i].wdat);
      bus_read(1'b0, {1'b0, tbl[i].ra}, r);
      check($sformatf("tbl[%0d]", i), {16'd0, r}, {16'd0, tbl[i].exp});
    end

    // Direction and set/clear
    bus_write(1'b0, 4'd1, 16'h00FF);
    ext16_en = 16'hFF00; ext16_val = 16'h5A00;
    bus_write(1'b0, 4'd0, 16'h1234);
    @(negedge clock);
    check("pins_dir_data", {16'd0, pins16}, {16'd0, 16'h5A34});
    bus_write(1'b0, 4'd2, 16'h0003);
    bus_write(1'b0, 4'd3, 16'h0010);
    @(negedge clock);
    check("pins_set_clr", {16'd0, pins16}, {16'd0, 16'h5A27});
    repeat (3) @(negedge clock);
    bus_read(1'b0, 4'd0, r);
    check("data_readback", {16'd0, r}, {16'd0, 16'h5A27});

    // Rising edge on pin0 -> irq after SYNC_STAGES+2 clocks
    bus_write(1'b0, 4'd1, 16'h0000);
    ext16_en = 16'hFFFF; ext16_val = 16'h0002;
    repeat (6) @(negedge clock);
    bus_write(1'b0, 4'd5, 16'h0001);
    bus_write(1'b0, 4'd4, 16'h0001);
    @(negedge clock);
    ext16_val = 16'h0003;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 3) check("rise_irq_clk3", {31'd0, irq16}, 32'd0);
      if (k == 4) check("rise_irq_clk4", {31'd0, irq16}, 32'd1);
    end
    bus_read(1'b0, 4'd7, r);
    check("rise_status", {16'd0, r}, {16'd0, 16'h0001});
    bus_write(1'b0, 4'd7, 16'h0001);
    check("w1c_irq_clk1", {31'd0, irq16}, 32'd1);
    @(negedge clock);
    check("w1c_irq_clk2", {31'd0, irq16}, 32'd0);

    // Falling edge on pin1 while masked, then unmask
    bus_write(1'b0, 4'd4, 16'h0000);
    bus_write(1'b0, 4'd6, 16'h0002);
    @(negedge clock);
    ext16_val = 16'h0001;
    repeat (6) @(negedge clock);
    check("fall_masked_irq", {31'd0, irq16}, 32'd0);
    bus_read(1'b0, 4'd7, r);
    check("fall_status", {16'd0, r}, {16'd0, 16'h0002});
    bus_write(1'b0, 4'd4, 16'h0002);
    check("unmask_irq_clk0", {31'd0, irq16}, 32'd0);
    @(negedge clock);
    check("unmask_irq_clk1", {31'd0, irq16}, 32'd1);

    // Edge detected in the same cycle as W1C of that bit
    ext16_val = 16'h0000;
    repeat (6) @(negedge clock);
    ext16_val = 16'h0001;
    @(negedge clock);
    @(negedge clock);
    cs16 = 1'b1; we = 1'b1; addr16 = 3'd7; wd = 16'h0001;
    @(negedge clock);
    we = 1'b0; cs16 = 1'b0;
    bus_read(1'b0, 4'd7, r);
    check("set_wins_w1c", {16'd0, r}, {16'd0, 16'h0003});

    // Read and write of the same address in one cycle
    @(negedge clock);
    cs16 = 1'b1; we = 1'b1; re = 1'b1; addr16 = 3'd4; wd = 16'hFFFF;
    @(negedge clock);
    we = 1'b0; re = 1'b0; cs16 = 1'b0;
    check("rw_same_pre", {16'd0, rd16}, {16'd0, 16'h0002});
    bus_read(1'b0, 4'd4, r);
    check("rw_same_post", {16'd0, r}, {16'd0, 16'hFFFF});

    // 8-pin instance
    bus_write(1'b1, 4'd1, 16'hFFFF);
    ext8_en = 8'h00;
    bus_write(1'b1, 4'd0, 16'hFFFF);
    repeat (4) @(negedge clock);
    bus_read(1'b1, 4'd0, r);
    check("p8_data", {16'd0, r}, {16'd0, 16'h00FF});
    bus_read(1'b1, 4'd1, r);
    check("p8_dir", {16'd0, r}, {16'd0, 16'h00FF});
    bus_read(1'b1, 4'd9, r);
    check("p8_unmapped", {16'd0, r}, 32'd0);
    check("p8_irq", {31'd0, irq8}, 32'd0);

    // Asynchronous reset in the middle of a read
    check("pre_reset_irq", {31'd0, irq16}, 32'd1);
    @(negedge clock);
    cs8 = 1'b1; re = 1'b1; addr8 = 4'd0;
    @(posedge clock);
    #2;
    check("p8_read_before_rst", {16'd0, rd8}, {16'd0, 16'h00FF});
    reset_n = 1'b0;
    ext16_en = 16'hFFFF; ext8_en = 8'hFF; ext16_val = 16'h0F0F; ext8_val = 8'hC3;
    #1;
    check("async_rst_rd8", {16'd0, rd8}, 32'd0);
    check("async_rst_irq16", {31'd0, irq16}, 32'd0);
    check("async_rst_rd16", {16'd0, rd16}, 32'd0);
    check("async_rst_pins16", {16'd0, pins16}, {16'd0, 16'h0F0F});
    check("async_rst_pins8", {24'd0, pins8}, {24'd0, 8'hC3});
    re = 1'b0; cs8 = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Randomized phase against settled-state model
    m_out = 0; m_dir = 0; m_mask = 0; m_rise = 0; m_fall = 0; m_status = 0;
    ext16_val = 16'($urandom);
    repeat (6) @(negedge clock);
    m_pins = ext16_val;
    for (int it = 0; it < 80; it++) begin
      int op;
      logic [2:0]  wa;
      logic [15:0] d;
      op = $urandom_range(0, 9);
      wa = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      if (op < 7) begin
        bus_write(1'b0, {1'b0, wa}, d);
        case (wa)
          3'd0: m_out = d;
          3'd1: begin m_dir = d; ext16_en = ~d; end
          3'd2: m_out = m_out | d;
          3'd3: m_out = m_out & ~d;
          3'd4: m_mask = d;
          3'd5: m_rise = d;
          3'd6: m_fall = d;
          default: m_status = m_status & ~d;
        endcase
      end else begin
        @(negedge clock);
        ext16_val = d;
      end
      repeat (6) @(negedge clock);
      newp = (m_dir & m_out) | (~m_dir & ext16_val);
      m_status = m_status | (newp & ~m_pins & m_rise) | (~newp & m_pins & m_fall);
      m_pins = newp;
      check($sformatf("rnd%0d_pins", it), {16'd0, pins16}, {16'd0, m_pins});
      check($sformatf("rnd%0d_irq", it), {31'd0, irq16}, {31'd0, |(m_status & m_mask)});
      ra = 3'($urandom_range(0, 7));
      bus_read(1'b0, {1'b0, ra}, r);
      check($sformatf("rnd%0d_read%0d", it, ra), {16'd0, r}, {16'd0, model_read(ra)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
